// File: rtl/hazard_gid.sv
// rtl/hazard_gid.sv - registered hazard-info decoder (Tuse/Tnew/A3/DPort) for one MIPS pipeline stage
// Optional MDU decode (mult/div/mthi/mtlo/mfhi/mflo) enabled by defining GID_MDU_EN.
module hazard_gid #(
  parameter logic [2:0] TUSE_NONE = 3'd7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] IR,
  input  logic [2:0]  Pipe,
  output logic [2:0]  Tuse_Rs,
  output logic [2:0]  Tuse_Rt,
  output logic        RegWriteNonZero,
  output logic [4:0]  A3,
  output logic [2:0]  Tnew,
  output logic [2:0]  DPort
);

  localparam logic [2:0] DP_NONE = 3'd0;
  localparam logic [2:0] DP_ALU  = 3'd1;
  localparam logic [2:0] DP_DM   = 3'd2;
  localparam logic [2:0] DP_PC8  = 3'd3;
`ifdef GID_MDU_EN
  localparam logic [2:0] DP_HILO = 3'd4;
`endif

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic       w_unused;

  assign w_op     = IR[31:26];
  assign w_funct  = IR[5:0];
  assign w_rt     = IR[20:16];
  assign w_rd     = IR[15:11];
  assign w_unused = ^{IR[25:21], IR[10:6]};

  logic [2:0] w_tuse_rs;
  logic [2:0] w_tuse_rt;
  logic       w_write;
  logic [4:0] w_dst;
  logic [2:0] w_base;
  logic [2:0] w_dport;

  always_comb begin
    w_tuse_rs = TUSE_NONE;
    w_tuse_rt = TUSE_NONE;
    w_write   = 1'b0;
    w_dst     = 5'd0;
    w_base    = 3'd0;
    w_dport   = DP_NONE;
    unique case (w_op)
      6'h00: begin
        unique case (w_funct)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2a, 6'h2b, 6'h04, 6'h06, 6'h07: begin
            w_tuse_rs = 3'd1;
            w_tuse_rt = 3'd1;
            w_write   = 1'b1;
            w_dst     = w_rd;
            w_base    = 3'd2;
            w_dport   = DP_ALU;
          end
          6'h00, 6'h02, 6'h03: begin
            w_tuse_rt = 3'd1;
            w_write   = 1'b1;
            w_dst     = w_rd;
            w_base    = 3'd2;
            w_dport   = DP_ALU;
          end
          6'h08: w_tuse_rs = 3'd0;
          6'h09: begin
            w_tuse_rs = 3'd0;
            w_write   = 1'b1;
            w_dst     = w_rd;
            w_base    = 3'd1;
            w_dport   = DP_PC8;
          end
`ifdef GID_MDU_EN
          6'h18, 6'h19, 6'h1a, 6'h1b: begin
            w_tuse_rs = 3'd1;
            w_tuse_rt = 3'd1;
          end
          6'h11, 6'h13: w_tuse_rs = 3'd1;
          6'h10, 6'h12: begin
            w_write = 1'b1;
            w_dst   = w_rd;
            w_base  = 3'd2;
            w_dport = DP_HILO;
          end
`endif
          default: ;
        endcase
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: begin
        w_tuse_rs = 3'd1;
        w_write   = 1'b1;
        w_dst     = w_rt;
        w_base    = 3'd2;
        w_dport   = DP_ALU;
      end
      6'h0f: begin
        w_write = 1'b1;
        w_dst   = w_rt;
        w_base  = 3'd2;
        w_dport = DP_ALU;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        w_tuse_rs = 3'd1;
        w_write   = 1'b1;
        w_dst     = w_rt;
        w_base    = 3'd3;
        w_dport   = DP_DM;
      end
      6'h28, 6'h29, 6'h2b: begin
        w_tuse_rs = 3'd1;
        w_tuse_rt = 3'd2;
      end
      6'h04, 6'h05: begin
        w_tuse_rs = 3'd0;
        w_tuse_rt = 3'd0;
      end
      6'h06, 6'h07: w_tuse_rs = 3'd0;
      6'h01: begin
        // only bltz (rt=0) and bgez (rt=1) are recognised in REGIMM
        if (w_rt == 5'd0 || w_rt == 5'd1) w_tuse_rs = 3'd0;
      end
      6'h02: ;
      6'h03: begin
        w_write = 1'b1;
        w_dst   = 5'd31;
        w_base  = 3'd1;
        w_dport = DP_PC8;
      end
      default: ;
    endcase
  end

  logic [2:0] w_pipe_eff;
  logic [2:0] w_elapsed;
  logic [2:0] w_tnew;

  // F and D both count as "not yet started"; codes above W saturate to W
  assign w_pipe_eff = (Pipe > 3'd4) ? 3'd4 : Pipe;
  assign w_elapsed  = (w_pipe_eff == 3'd0) ? 3'd0 : (w_pipe_eff - 3'd1);
  assign w_tnew     = (w_write && (w_base > w_elapsed)) ? (w_base - w_elapsed) : 3'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Tuse_Rs         <= TUSE_NONE;
      Tuse_Rt         <= TUSE_NONE;
      RegWriteNonZero <= 1'b0;
      A3              <= 5'd0;
      Tnew            <= 3'd0;
      DPort           <= DP_NONE;
    end else begin
      Tuse_Rs         <= w_tuse_rs;
      Tuse_Rt         <= w_tuse_rt;
      RegWriteNonZero <= w_write && (w_dst != 5'd0);
      A3              <= w_write ? w_dst : 5'd0;
      Tnew            <= w_tnew;
      DPort           <= w_dport;
    end
  end

endmodule

// File: tb/tb_hazard_gid.sv
// tb/tb_hazard_gid.sv - directed self-checking bench for hazard_gid
module tb_hazard_gid;

  logic        clk;
  logic        reset_n;
  logic [31:0] IR;
  logic [2:0]  Pipe;
  logic [2:0]  Tuse_Rs;
  logic [2:0]  Tuse_Rt;
  logic        RegWriteNonZero;
  logic [4:0]  A3;
  logic [2:0]  Tnew;
  logic [2:0]  DPort;

  int checks = 0;
  int errors = 0;

  hazard_gid dut (
    .clk(clk),
    .reset_n(reset_n),
    .IR(IR),
    .Pipe(Pipe),
    .Tuse_Rs(Tuse_Rs),
    .Tuse_Rt(Tuse_Rt),
    .RegWriteNonZero(RegWriteNonZero),
    .A3(A3),
    .Tnew(Tnew),
    .DPort(DPort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] w_obs;
  assign w_obs = {Tuse_Rs, Tuse_Rt, RegWriteNonZero, A3, Tnew, DPort};

  function automatic logic [17:0] pk(input logic [2:0] rs, input logic [2:0] rt,
                                     input logic rw, input logic [4:0] a3,
                                     input logic [2:0] tn, input logic [2:0] dp);
    return {rs, rt, rw, a3, tn, dp};
  endfunction

  task automatic drive(input logic [31:0] ir, input logic [2:0] pipe);
    @(negedge clk);
    IR   = ir;
    Pipe = pipe;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [17:0] exp;
    exp = pk(3'd7, 3'd7, 1'b0, 5'd0, 3'd0, 3'd0);
    reset_n = 1'b1;
    IR      = 32'h00430820;
    Pipe    = 3'd4;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (w_obs !== exp) begin
      errors++;
      $display("FAIL reset_immediate got %h exp %h", w_obs, exp);
    end
    @(posedge clk);
    #1;
    checks++;
    if (w_obs !== exp) begin
      errors++;
      $display("FAIL reset_held_over_clk got %h exp %h", w_obs, exp);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    exp = pk(3'd1, 3'd1, 1'b1, 5'd1, 3'd0, 3'd1);
    checks++;
    if (w_obs !== exp) begin
      errors++;
      $display("FAIL reset_release_add got %h exp %h", w_obs, exp);
    end
  endtask

  task automatic test_alu;
    logic [31:0] irs [6] = '{32'h00430820, 32'h00430820, 32'h00430820, 32'h00430820,
                             32'h34450001, 32'h3C050001};
    logic [2:0]  pps [6] = '{3'd2, 3'd0, 3'd7, 3'd3, 3'd1, 3'd1};
    logic [17:0] exps[6];
    exps[0] = pk(3'd1, 3'd1, 1'b1, 5'd1, 3'd1, 3'd1);
    exps[1] = pk(3'd1, 3'd1, 1'b1, 5'd1, 3'd2, 3'd1);
    exps[2] = pk(3'd1, 3'd1, 1'b1, 5'd1, 3'd0, 3'd1);
    exps[3] = pk(3'd1, 3'd1, 1'b1, 5'd1, 3'd0, 3'd1);
    exps[4] = pk(3'd1, 3'd7, 1'b1, 5'd5, 3'd2, 3'd1);
    exps[5] = pk(3'd7, 3'd7, 1'b1, 5'd5, 3'd2, 3'd1);
    for (int i = 0; i < 6; i++) begin
      drive(irs[i], pps[i]);
      checks++;
      if (w_obs !== exps[i]) begin
        errors++;
        $display("FAIL alu[%0d] ir=%h pipe=%0d got %h exp %h", i, irs[i], pps[i], w_obs, exps[i]);
      end
    end
  endtask

  task automatic test_load;
    logic [2:0]  pps [4] = '{3'd2, 3'd3, 3'd4, 3'd1};
    logic [2:0]  tns [4] = '{3'd2, 3'd1, 3'd0, 3'd3};
    logic [17:0] exp;
    for (int i = 0; i < 4; i++) begin
      drive(32'h8C410000, pps[i]);
      exp = pk(3'd1, 3'd7, 1'b1, 5'd1, tns[i], 3'd2);
      checks++;
      if (w_obs !== exp) begin
        errors++;
        $display("FAIL load pipe=%0d got %h exp %h", pps[i], w_obs, exp);
      end
    end
  endtask

  task automatic test_store_branch;
    logic [31:0] irs [6] = '{32'hAC410000, 32'h10220009, 32'h04210004, 32'h04200004,
                             32'h04220004, 32'h18400003};
    logic [17:0] exps[6];
    exps[0] = pk(3'd1, 3'd2, 1'b0, 5'd0, 3'd0, 3'd0);
    exps[1] = pk(3'd0, 3'd0, 1'b0, 5'd0, 3'd0, 3'd0);
    exps[2] = pk(3'd0, 3'd7, 1'b0, 5'd0, 3'd0, 3'd0);
    exps[3] = pk(3'd0, 3'd7, 1'b0, 5'd0, 3'd0, 3'd0);
    exps[4] = pk(3'd7, 3'd7, 1'b0, 5'd0, 3'd0, 3'd0);
    exps[5] = pk(3'd0, 3'd7, 1'b0, 5'd0, 3'd0, 3'd0);
    for (int i = 0; i < 6; i++) begin
      drive(irs[i], 3'd1);
      checks++;
      if (w_obs !== exps[i]) begin
        errors++;
        $display("FAIL store_branch[%0d] ir=%h got %h exp %h", i, irs[i], w_obs, exps[i]);
      end
    end
  endtask

  task automatic test_jump;
    logic [31:0] irs [6] = '{32'h0C000C32, 32'h0C000C32, 32'h00400809, 32'h00400008,
                             32'h08000000, 32'h00020800};
    logic [2:0]  pps [6] = '{3'd1, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1};
    logic [17:0] exps[6];
    exps[0] = pk(3'd7, 3'd7, 1'b1, 5'd31, 3'd1, 3'd3);
    exps[1] = pk(3'd7, 3'd7, 1'b1, 5'd31, 3'd0, 3'd3);
    exps[2] = pk(3'd0, 3'd7, 1'b1, 5'd1, 3'd1, 3'd3);
    exps[3] = pk(3'd0, 3'd7, 1'b0, 5'd0, 3'd0, 3'd0);
    exps[4] = pk(3'd7, 3'd7, 1'b0, 5'd0, 3'd0, 3'd0);
    exps[5] = pk(3'd7, 3'd1, 1'b1, 5'd1, 3'd2, 3'd1);
    for (int i = 0; i < 6; i++) begin
      drive(irs[i], pps[i]);
      checks++;
      if (w_obs !== exps[i]) begin
        errors++;
        $display("FAIL jump[%0d] ir=%h got %h exp %h", i, irs[i], w_obs, exps[i]);
      end
    end
  endtask

  task automatic test_zero_dest_and_unknown;
    logic [31:0] irs [4] = '{32'h00000000, 32'h00430020, 32'hFC000000, 32'h0000003F};
    logic [17:0] exps[4];
    exps[0] = pk(3'd7, 3'd1, 1'b0, 5'd0, 3'd0, 3'd1);
    exps[1] = pk(3'd1, 3'd1, 1'b0, 5'd0, 3'd0, 3'd1);
    exps[2] = pk(3'd7, 3'd7, 1'b0, 5'd0, 3'd0, 3'd0);
    exps[3] = pk(3'd7, 3'd7, 1'b0, 5'd0, 3'd0, 3'd0);
    for (int i = 0; i < 4; i++) begin
      drive(irs[i], 3'd4);
      checks++;
      if (w_obs !== exps[i]) begin
        errors++;
        $display("FAIL zero_unknown[%0d] ir=%h got %h exp %h", i, irs[i], w_obs, exps[i]);
      end
    end
  endtask

  task automatic test_mdu;
    logic [17:0] exp_mfhi;
    logic [17:0] exp_mult;
`ifdef GID_MDU_EN
    exp_mfhi = pk(3'd7, 3'd7, 1'b1, 5'd1, 3'd2, 3'd4);
    exp_mult = pk(3'd1, 3'd1, 1'b0, 5'd0, 3'd0, 3'd0);
`else
    exp_mfhi = pk(3'd7, 3'd7, 1'b0, 5'd0, 3'd0, 3'd0);
    exp_mult = pk(3'd7, 3'd7, 1'b0, 5'd0, 3'd0, 3'd0);
`endif
    drive(32'h00000810, 3'd1);
    checks++;
    if (w_obs !== exp_mfhi) begin
      errors++;
      $display("FAIL mdu_mfhi got %h exp %h", w_obs, exp_mfhi);
    end
    drive(32'h00220018, 3'd1);
    checks++;
    if (w_obs !== exp_mult) begin
      errors++;
      $display("FAIL mdu_mult got %h exp %h", w_obs, exp_mult);
    end
  endtask

  task automatic test_back_to_back;
    logic [17:0] exp_lw;
    logic [17:0] exp_sw;
    exp_lw = pk(3'd1, 3'd7, 1'b1, 5'd1, 3'd2, 3'd2);
    exp_sw = pk(3'd1, 3'd2, 1'b0, 5'd0, 3'd0, 3'd0);
    drive(32'h8C410000, 3'd2);
    @(negedge clk);
    IR   = 32'hAC410000;
    Pipe = 3'd1;
    #1;
    checks++;
    if (w_obs !== exp_lw) begin
      errors++;
      $display("FAIL b2b_hold_before_edge got %h exp %h", w_obs, exp_lw);
    end
    @(posedge clk);
    #1;
    checks++;
    if (w_obs !== exp_sw) begin
      errors++;
      $display("FAIL b2b_after_edge got %h exp %h", w_obs, exp_sw);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (w_obs !== pk(3'd7, 3'd7, 1'b0, 5'd0, 3'd0, 3'd0)) begin
      errors++;
      $display("FAIL midop_reset got %h exp %h", w_obs, pk(3'd7, 3'd7, 1'b0, 5'd0, 3'd0, 3'd0));
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(32'h0C000C32, 3'd1);
    checks++;
    if (w_obs !== pk(3'd7, 3'd7, 1'b1, 5'd31, 3'd1, 3'd3)) begin
      errors++;
      $display("FAIL post_reset_jal got %h exp %h", w_obs, pk(3'd7, 3'd7, 1'b1, 5'd31, 3'd1, 3'd3));
    end
  endtask

  initial begin
    reset_n = 1'b1;
    IR      = 32'h0;
    Pipe    = 3'd0;
    test_reset();
    test_alu();
    test_load();
    test_store_branch();
    test_jump();
    test_zero_dest_and_unknown();
    test_mdu();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_gid.md
Name:
hazard_gid

Overview:
Registered hazard-information decoder for the 5-stage MIPS pipeline hazard unit. It decodes a 32-bit instruction word and the pipeline stage that instruction occupies. It produces:
- operand-use deadlines (Tuse) for rs and rt;
- result-ready countdown (Tnew);
- destination register (A3) and a nonzero-write flag;
- forwarding data-source code (DPort).
One instance exists per pipeline stage register.

Parameters:
TUSE_NONE, 7, Tuse value reported for an operand the instruction does not read.

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset (asynchronous, active-low)
- IR  input  32  instruction word
- Pipe  input  3  stage code: 0=F, 1=D, 2=E, 3=M, 4=W; 5-7 treated as W
- Tuse_Rs  output  3  cycles after D at which rs is first needed
- Tuse_Rt  output  3  cycles after D at which rt is first needed
- RegWriteNonZero  output  1  instruction writes a GPR and A3 != 0
- A3  output  5  destination GPR; 0 when the instruction does not write
- Tnew  output  3  cycles until the result exists, given current Pipe
- DPort  output  3  result source: 0 none, 1 ALU, 2 DM load data, 3 PC+8, 4 HI/LO

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: Tuse_Rs=Tuse_Rt=7; RegWriteNonZero=0; A3=0; Tnew=0; DPort=0.
- Decode is combinational; all outputs are registered on the rising edge of clk, giving 1-cycle latency from IR/Pipe to outputs.
- Async reset asserted mid-operation clears outputs immediately. The first capture occurs on the first clk edge after deassertion.
- Tuse encoding: 0 = needed in D, 1 = needed in E, 2 = needed in M, 7 = unused.
- Tuse and decode classes:
  - ALU R-type (add addu sub subu and or xor nor slt sltu sllv srlv srav): rs=1, rt=1; writes rd; base T=2; DPort=1.
  - sll srl sra: rs=7, rt=1; writes rd; base T=2; DPort=1.
  - I-type ALU (addi addiu andi ori xori slti sltiu): rs=1, rt=7; writes rt; base T=2; DPort=1.
  - lui: rs=7, rt=7; writes rt; base T=2; DPort=1.
  - Loads (lw lb lbu lh lhu): rs=1, rt=7; writes rt; base T=3; DPort=2.
  - Stores (sw sh sb): rs=1, rt=2; no write.
  - beq/bne: rs=0, rt=0; no write.
  - blez, bgtz, bltz (op 1, rt=0), bgez (op 1, rt=1): rs=0, rt=7; no write.
  - j: no reads, no write.
  - jal: writes 31; base T=1; DPort=3.
  - jr: rs=0; no write.
  - jalr: rs=0; writes rd; base T=1; DPort=3.
- Tnew = max(base T − max(Pipe−1, 0), 0). Pipe 0 and 1 both yield base T. Non-writing instructions give Tnew=0 and DPort=0.
- A3 follows the write class above, else 0. RegWriteNonZero = write && (A3 != 0). A write to $0 gives A3=0, RegWriteNonZero=0, and DPort as decoded.
- Unknown opcode/funct: treated as nop (Tuse 7/7, no write, Tnew 0, DPort 0).
- IR=0 (sll $0,$0,0) decodes as sll: rs=7, rt=1, A3=0, RWNZ=0.

Optional Feature:
GID_MDU_EN:
- Defined:
  - mult, multu, div, divu: rs=1, rt=1; no GPR write.
  - mthi, mtlo: rs=1, rt=7; no GPR write.
  - mfhi, mflo: rs=7, rt=7; write rd; base T=2; DPort=4.
- Undefined: all six MDU instructions plus mfhi/mflo decode as unknown (nop).

Test Plan:
- reset_n=0 with IR=0x00430820 applied → outputs immediately Tuse 7/7, A3 0, Tnew 0, DPort 0, RWNZ 0. Release reset, clock → add decode appears.
- IR=0x00430820 (add $1,$2,$3), Pipe=4, one edge → Tuse_Rs=1, Tuse_Rt=1, RWNZ=1, A3=1, Tnew=0, DPort=1. Same IR with Pipe=2 → Tnew=1.
- IR=0x8C410000 (lw $1,0($2)): Pipe=2 → Tnew=2, A3=1, DPort=2, Tuse 1/7. Pipe=3 → Tnew=1. Pipe=4 → Tnew=0.
- IR=0xAC410000 (sw) → Tuse 1/2, RWNZ=0, A3=0, DPort=0. IR=0x10220009 (beq) → Tuse 0/0. IR=0x04210004 (bgez) → Tuse 0/7.
- IR=0x0C000C32 (jal), Pipe=1 → A3=31, Tnew=1, DPort=3. IR=0x00400809 (jalr $1,$2) → Tuse_Rs=0, A3=1, DPort=3. IR=0x00020800 (sll) → Tuse 7/1, A3=1.
- With GID_MDU_EN: IR=0x00000810 (mfhi $1) → A3=1, DPort=4; IR=0x00220018 (mult) → Tuse 1/1, RWNZ=0. Without GID_MDU_EN: IR=0x00000810 → A3=0, DPort=0, Tuse 7/7.
